// File: rtl/ifetch_buffer_if.sv
// Fetch-side bundle for the instruction fetch buffer: memory request/response,
// EXE redirect, and the decoupled instruction stream toward ID.
interface ifetch_buffer_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        err_unexpected;

  modport slave (
    output req_valid, req_addr,
    input  req_ready,
    input  rsp_valid, rsp_data,
    input  redirect, redirect_pc,
    output out_valid, out_pc, out_instr,
    input  out_ready,
    output err_unexpected
  );

  modport master (
    input  req_valid, req_addr,
    output req_ready,
    output rsp_valid, rsp_data,
    output redirect, redirect_pc,
    input  out_valid, out_pc, out_instr,
    output out_ready,
    input  err_unexpected
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues credit-limited fetches, queues returned words
// with their PCs, and flushes on redirect while discarding stale in-flight responses.
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ifetch_buffer_if.slave   bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic          r_err;

  logic [CW:0]   w_credit;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_ok;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_head_valid;
  logic [31:0]   w_redirect_pc;

  // Handshake qualification; in-flight words still owed to the FIFO count against credit.
  always_comb begin
    w_credit      = {1'b0, r_count} + {1'b0, r_outstanding - r_drop_cnt};
    w_req_valid   = !i_rst && !bus.redirect && (w_credit < DEPTH_W);
    w_req_fire    = w_req_valid && bus.req_ready;
    w_rsp_ok      = bus.rsp_valid && (r_outstanding != '0);
    w_drop        = w_rsp_ok && (r_drop_cnt != '0);
    w_push        = w_rsp_ok && (r_drop_cnt == '0) && !bus.redirect;
    w_head_valid  = (r_count != '0);
    w_pop         = w_head_valid && bus.out_ready && !bus.redirect;
    w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  assign bus.req_valid      = w_req_valid;
  assign bus.req_addr       = r_fetch_pc;
  assign bus.out_valid      = w_head_valid;
  assign bus.out_pc         = w_head_valid ? r_pc_mem[r_rd_ptr]    : 32'h0000_0000;
  assign bus.out_instr      = w_head_valid ? r_instr_mem[r_rd_ptr] : NOP;
  assign bus.err_unexpected = r_err;

  // Entry storage; contents are only observed through count, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_rsp_pc;
      r_instr_mem[r_wr_ptr] <= bus.rsp_data;
    end
  end

  // Control state: PCs, pointers, occupancy and in-flight bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC_A;
      r_rsp_pc      <= RESET_PC_A;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_err         <= 1'b0;
    end else begin
      if (bus.rsp_valid && (r_outstanding == '0)) begin
        r_err <= 1'b1;
      end
      if (bus.redirect) begin
        // Every word still in flight now belongs to the abandoned path.
        r_fetch_pc    <= w_redirect_pc;
        r_rsp_pc      <= w_redirect_pc;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
        r_outstanding <= r_outstanding - CW'(w_rsp_ok);
        r_drop_cnt    <= r_outstanding - CW'(w_rsp_ok);
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
        r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with an in-order, fixed-latency memory model.
module tb_ifetch_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   lat;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  ifetch_buffer_if bus ();

  ifetch_buffer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1234_5600;
  endfunction

  // One clock: record handshakes seen before the edge, then drive the memory response.
  task automatic tick();
    logic        fire;
    logic        taken;
    logic [31:0] a;
    fire  = bus.req_valid && bus.req_ready;
    a     = bus.req_addr;
    taken = bus.rsp_valid && (mq.size() > 0) && (mq[0].due <= cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
    end else begin
      if (taken) void'(mq.pop_front());
      if (fire) mq.push_back('{addr: a, due: cyc + lat - 1});
    end
    bus.rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.rsp_data  = (mq.size() > 0) ? instr_of(mq[0].addr) : 32'h0000_0000;
  endtask

  task automatic do_reset();
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0000_0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", bus.req_valid); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc: got %h expected 00000000", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_out_instr: got %h expected 00000013", bus.out_instr); end
    checks++; if (bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err_unexpected); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", bus.req_valid); end
    checks++; if (bus.req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 00000000", bus.req_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; bus.req_ready = 1'b1; bus.out_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'(4 * i)); end
      checks++; if (bus.out_instr !== instr_of(32'(4 * i))) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, bus.out_instr, instr_of(32'(4 * i))); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; bus.req_ready = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_blocked: got %b expected 0", bus.req_valid); end
    checks++; if (bus.req_addr !== 32'h10) begin errors++; $display("FAIL bp_fetch_pc: got %h expected 00000010", bus.req_addr); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL bp_pop_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'(4 * i)); end
      checks++; if (bus.out_instr !== instr_of(32'(4 * i))) begin errors++; $display("FAIL bp_pop_instr[%0d]: got %h expected %h", i, bus.out_instr, instr_of(32'(4 * i))); end
      if (i == 1) begin
        checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL bp_resume_valid: got %b expected 1", bus.req_valid); end
        checks++; if (bus.req_addr !== 32'h10) begin errors++; $display("FAIL bp_resume_addr: got %h expected 00000010", bus.req_addr); end
      end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3; bus.req_ready = 1'b1; bus.out_ready = 1'b1;
    tick();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100;
    #1;
    checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL rd_req_during: got %b expected 0", bus.req_valid); end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL rd_req_after: got %b expected 1", bus.req_valid); end
    checks++; if (bus.req_addr !== 32'h100) begin errors++; $display("FAIL rd_req_addr: got %h expected 00000100", bus.req_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped[%0d]: got out_valid %b expected 0", i, bus.out_valid); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rd_first_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL rd_first_pc: got %h expected 00000100", bus.out_pc); end
    checks++; if (bus.out_instr !== instr_of(32'h100)) begin errors++; $display("FAIL rd_first_instr: got %h expected %h", bus.out_instr, instr_of(32'h100)); end
    tick();
    checks++; if (bus.out_pc !== 32'h104) begin errors++; $display("FAIL rd_second_pc: got %h expected 00000104", bus.out_pc); end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    lat = 1; bus.req_ready = 1'b1; bus.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL col_pre_pc: got %h expected 00000000", bus.out_pc); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL col_flushed: got %b expected 0", bus.out_valid); end
    checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL col_req_valid: got %b expected 1", bus.req_valid); end
    checks++; if (bus.req_addr !== 32'h100) begin errors++; $display("FAIL col_req_addr: got %h expected 00000100", bus.req_addr); end
    tick();
    tick();
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL col_first_pc: got %h expected 00000100", bus.out_pc); end
    checks++; if (bus.out_instr !== instr_of(32'h100)) begin errors++; $display("FAIL col_first_instr: got %h expected %h", bus.out_instr, instr_of(32'h100)); end
  endtask

  task automatic test_spurious();
    do_reset();
    bus.req_ready = 1'b0; bus.out_ready = 1'b1;
    bus.rsp_valid = 1'b1; bus.rsp_data = 32'hCAFE_0000;
    tick();
    checks++; if (bus.err_unexpected !== 1'b1) begin errors++; $display("FAIL sp_err_set: got %b expected 1", bus.err_unexpected); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sp_no_push: got %b expected 0", bus.out_valid); end
    tick();
    checks++; if (bus.err_unexpected !== 1'b1) begin errors++; $display("FAIL sp_err_sticky: got %b expected 1", bus.err_unexpected); end
    do_reset();
    checks++; if (bus.err_unexpected !== 1'b0) begin errors++; $display("FAIL sp_err_cleared: got %b expected 0", bus.err_unexpected); end
  endtask

  task automatic test_reset_full();
    do_reset();
    lat = 1; bus.req_ready = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rf_pre_full: got %b expected 1", bus.out_valid); end
    rst = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL rf_out_instr: got %h expected 00000013", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rf_out_pc: got %h expected 00000000", bus.out_pc); end
    checks++; if (bus.req_addr !== 32'h0) begin errors++; $display("FAIL rf_req_addr: got %h expected 00000000", bus.req_addr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_valid !== 1'b1) begin errors++; $display("FAIL rf_req_resume: got %b expected 1", bus.req_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1;
    rst = 1'b1;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collide();
    test_spurious();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entries (power of 2, 2..16).
REQ-002 Parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  output  1  fetch request to instruction memory.
REQ-006 req_addr  output  32  word-aligned fetch address.
REQ-007 req_ready  input  1  memory accepts request this cycle.
REQ-008 rsp_valid  input  1  instruction word returned (in request order, latency >= 1 cycle).
REQ-009 rsp_data  input  32  returned instruction.
REQ-010 redirect  input  1  taken branch/jump from EXE (PCSrc); flushes buffer.
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 out_valid  output  1  head entry available to ID stage.
REQ-013 out_pc  output  32  PC of head instruction.
REQ-014 out_instr  output  32  head instruction.
REQ-015 out_ready  input  1  ID stage consumes head (low during load-use stall).
REQ-016 err_unexpected  output  1  sticky flag: response with nothing outstanding.

Function
REQ-017 State: fetch_pc, rsp_pc, FIFO of {pc,instr} with count 0..DEPTH, outstanding counter 0..DEPTH, drop_cnt 0..DEPTH.
REQ-018 req_addr SHALL equal fetch_pc with bits[1:0] forced to 0.
REQ-019 req_valid SHALL be high iff Reset low, redirect low, and count + (outstanding - drop_cnt) < DEPTH (credit rule; FIFO never overflows).
REQ-020 req_valid && req_ready SHALL increment fetch_pc by 4 (wrap mod 2^32) and outstanding by 1.
REQ-021 rsp_valid with outstanding > 0 SHALL decrement outstanding; if drop_cnt > 0 it decrements drop_cnt and discards data, else it pushes {rsp_pc, rsp_data} and rsp_pc += 4.
REQ-022 Same-cycle request accept and response SHALL leave outstanding unchanged.
REQ-023 rsp_valid with outstanding == 0 SHALL be ignored and set err_unexpected until Reset.
REQ-024 out_valid = (count != 0); out_pc/out_instr SHALL show head entry combinationally from registers; when out_valid low, out_pc = 0 and out_instr = 32'h00000013 (NOP).
REQ-025 out_valid && out_ready SHALL pop head; push and pop in the same cycle SHALL keep count unchanged, including at count == DEPTH.
REQ-026 Push-to-out_valid latency SHALL be 1 cycle (entry visible the cycle after rsp_valid).
REQ-027 redirect SHALL in one cycle: count <- 0, fetch_pc <- rsp_pc <- {redirect_pc[31:2],2'b00}, drop_cnt <- outstanding - rsp_valid, outstanding <- outstanding - rsp_valid; any same-cycle rsp_data and pop are discarded.
REQ-028 First request after redirect SHALL be issued the following cycle if credit allows.
REQ-029 redirect SHALL take priority over push, pop and request in the same cycle.

Reset
REQ-030 Reset SHALL set fetch_pc = rsp_pc = RESET_PC, count = outstanding = drop_cnt = 0, err_unexpected = 0, req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 32'h00000013.
REQ-031 Reset mid-operation SHALL drop all buffered and in-flight state; memory is reset by the same Reset and returns no stale responses.
REQ-032 First req_valid SHALL assert the cycle after Reset deasserts, req_addr = RESET_PC.

Verification
REQ-033 Stream: 1-cycle memory, req_ready = out_ready = 1 -> out_pc 0,4,8,... consecutive every cycle, instr matches memory.
REQ-034 Backpressure: out_ready = 0 for 10 cycles -> count reaches 4, req_valid low, no loss; release -> PCs 0..12 popped in order, fetch resumes at 16.
REQ-035 Redirect with 2 in-flight (latency 3) to 0x100 -> next 2 responses dropped, first out_pc = 0x100, drop_cnt returns to 0.
REQ-036 Redirect same cycle as rsp_valid and pop -> response discarded, out_valid 0 next cycle, redirect_pc 0x103 fetched as 0x100.
REQ-037 Spurious rsp_valid after reset with nothing requested -> err_unexpected = 1, count stays 0; Reset clears it.
REQ-038 Reset asserted with full FIFO -> next cycle out_valid = 0, out_instr = 0x00000013, req_addr = RESET_PC.
